// File: rtl/mmcm_servo_pkg.sv
// mmcm_servo_pkg: shared types and helpers for the MMCM phase-shift servo.
//   ps_state_e  : stepper FSM states (IDLE / PULSE / WAIT)
//   PS_INC/DEC  : PSINCDEC encodings
//   step_w()    : width of a per-sample step counter for a given MAX_STEPS
package mmcm_servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } ps_state_e;

  localparam logic PS_INC = 1'b1;
  localparam logic PS_DEC = 1'b0;

  // Bits needed to hold 0..max_steps.
  function automatic int step_w(input int max_steps);
    return (max_steps < 1) ? 1 : $clog2(max_steps + 1);
  endfunction

endpackage

// File: rtl/ps_timeout_counter.sv
// ps_timeout_counter: loadable down-counter that times a PSDONE wait.
//   clk, rst_n : clock, async active-low reset
//   load       : restart the wait (count <= PSDONE_TIMEOUT-1)
//   en         : count down one cycle of waiting
//   tc         : terminal count, high when the count is zero
// Loaded count PSDONE_TIMEOUT-1 corresponds to "0 cycles elapsed"; tc marks
// the cycle where PSDONE_TIMEOUT-1 cycles have elapsed.
module ps_timeout_counter #(
  parameter int PSDONE_TIMEOUT = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (PSDONE_TIMEOUT < 2) ? 1 : $clog2(PSDONE_TIMEOUT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PSDONE_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (en && (cnt != '0))
      cnt <= cnt - ONE;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mmcm_ps_stepper.sv
// mmcm_ps_stepper: turns filtered phase-error samples into bounded bursts of
// MMCM dynamic phase-shift steps, paced by PSDONE.
//   clk         : system clock (also MMCM PSCLK)
//   reset_in_n  : async active-low reset
//   CE, err_in  : sample strobe and signed filtered phase error
//   enable      : servo run enable
//   psen        : one-cycle PSEN pulse per step
//   psincdec    : step direction (1 = increment), held through the wait
//   psdone      : MMCM step-complete handshake
//   busy        : burst in progress (state != IDLE)
//   position    : signed, saturating count of completed steps
//   timeout_err : sticky flag, PSDONE never came back for a step
module mmcm_ps_stepper
  import mmcm_servo_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEADBAND       = 4,
  parameter int MAX_STEPS      = 8,
  parameter int PSDONE_TIMEOUT = 63
) (
  input  logic                    clk,
  input  logic                    reset_in_n,
  input  logic                    CE,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] err_in,
  output logic                    psen,
  output logic                    psincdec,
  input  logic                    psdone,
  output logic                    busy,
  output logic signed [WIDTH-1:0] position,
  output logic                    timeout_err
);

  localparam int SW = step_w(MAX_STEPS);

  localparam logic [WIDTH-1:0]        DB_U    = WIDTH'(DEADBAND);
  localparam logic [WIDTH-1:0]        MAX_U   = WIDTH'(MAX_STEPS);
  localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE_S   = WIDTH'(1);
  localparam logic [SW-1:0]           ONE_R   = SW'(1);

  ps_state_e      state;
  logic [SW-1:0]  remaining;

  logic [WIDTH-1:0]        mag;
  logic [WIDTH-1:0]        excess;
  logic [WIDTH-1:0]        clamped;
  logic [SW-1:0]           step_cnt;
  logic                    need_steps;
  logic signed [WIDTH-1:0] pos_step;
  logic                    tmo_tc;

  // Magnitude with the most-negative input pinned to +max so it cannot wrap.
  // The clamp happens at full width; truncation is only safe afterwards.
  always_comb begin
    mag = '0;
    if (err_in == POS_MIN)
      mag = POS_MAX;
    else if (err_in[WIDTH-1])
      mag = -err_in;
    else
      mag = err_in;
    need_steps = (mag > DB_U);
    excess     = mag - DB_U;
    clamped    = (excess > MAX_U) ? MAX_U : excess;
    step_cnt   = clamped[SW-1:0];
  end

  // Position after one completed step in the current direction, saturating.
  always_comb begin
    pos_step = position;
    if (psincdec == PS_INC) begin
      if (position != POS_MAX) pos_step = position + ONE_S;
    end else begin
      if (position != POS_MIN) pos_step = position - ONE_S;
    end
  end

  ps_timeout_counter #(
    .PSDONE_TIMEOUT(PSDONE_TIMEOUT)
  ) u_tmo (
    .clk  (clk),
    .rst_n(reset_in_n),
    .load (state == PULSE),
    .en   (state == WAIT),
    .tc   (tmo_tc)
  );

  // psen/busy are registered alongside the state so they change with it.
  // psincdec doubles as the burst direction register.
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state       <= IDLE;
      psen        <= 1'b0;
      psincdec    <= PS_DEC;
      busy        <= 1'b0;
      position    <= '0;
      timeout_err <= 1'b0;
      remaining   <= '0;
    end else begin
      case (state)
        IDLE: begin
          psen <= 1'b0;
          if (CE && enable && need_steps) begin
            remaining <= step_cnt;
            psincdec  <= err_in[WIDTH-1] ? PS_DEC : PS_INC;
            psen      <= 1'b1;
            busy      <= 1'b1;
            state     <= PULSE;
          end
        end
        PULSE: begin
          psen      <= 1'b0;
          remaining <= remaining - ONE_R;
          state     <= WAIT;
        end
        WAIT: begin
          // psdone wins over a same-cycle terminal count.
          if (psdone) begin
            position <= pos_step;
            if ((remaining != '0) && enable) begin
              psen  <= 1'b1;
              state <= PULSE;
            end else begin
              remaining <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else if (tmo_tc) begin
            timeout_err <= 1'b1;
            remaining   <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          psen      <= 1'b0;
          busy      <= 1'b0;
          remaining <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_ps_stepper.sv
// Directed bench for mmcm_ps_stepper. Main instance uses the default
// parameters; a second 8-bit instance exercises position saturation.
module tb_mmcm_ps_stepper;

  logic clk = 1'b0;
  logic reset_in_n;
  logic enable;

  // main instance (WIDTH=32, DEADBAND=4, MAX_STEPS=8, PSDONE_TIMEOUT=63)
  logic               ce;
  logic signed [31:0] err;
  logic               psen, psincdec, psdone, busy, terr;
  logic signed [31:0] pos;

  // saturation instance (WIDTH=8, DEADBAND=0, MAX_STEPS=255, PSDONE_TIMEOUT=4)
  logic              ce2;
  logic signed [7:0] err2;
  logic              psen2, psincdec2, psdone2, busy2, terr2;
  logic signed [7:0] pos2;

  int n_chk = 0;
  int n_err = 0;

  // psdone responder controls
  logic resp_on  = 1'b0;
  int   resp_dly = 3;
  logic resp_pd  = 1'b0;
  logic stray_pd = 1'b0;
  logic resp2_pd = 1'b0;

  int pulses = 0, incs = 0, decs = 0;
  int pulses2 = 0, incs2 = 0, decs2 = 0;

  assign psdone  = resp_pd | stray_pd;
  assign psdone2 = resp2_pd;

  always #5 clk = ~clk;

  mmcm_ps_stepper dut (
    .clk(clk), .reset_in_n(reset_in_n), .CE(ce), .enable(enable),
    .err_in(err), .psen(psen), .psincdec(psincdec), .psdone(psdone),
    .busy(busy), .position(pos), .timeout_err(terr)
  );

  mmcm_ps_stepper #(.WIDTH(8), .DEADBAND(0), .MAX_STEPS(255), .PSDONE_TIMEOUT(4)) dut2 (
    .clk(clk), .reset_in_n(reset_in_n), .CE(ce2), .enable(enable),
    .err_in(err2), .psen(psen2), .psincdec(psincdec2), .psdone(psdone2),
    .busy(busy2), .position(pos2), .timeout_err(terr2)
  );

  // pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (psen) begin
      pulses++;
      if (psincdec) incs++; else decs++;
    end
    if (psen2) begin
      pulses2++;
      if (psincdec2) incs2++; else decs2++;
    end
  end

  // main responder: psdone resp_dly cycles after each psen
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(posedge clk); #1;
      resp_pd = 1'b0;
      if (psen && resp_on) cd = resp_dly;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) resp_pd = resp_on;
      end
    end
  end

  // saturation-instance responder: psdone in the cycle right after psen
  initial begin
    forever begin
      @(posedge clk); #1;
      resp2_pd = 1'b0;
      if (psen2) begin
        @(posedge clk); #1;
        resp2_pd = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present one sample; returns #1 after the accepting edge
  task automatic send(input logic signed [31:0] e);
    @(negedge clk);
    ce = 1'b1; err = e;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic send2(input logic signed [7:0] e);
    @(negedge clk);
    ce2 = 1'b1; err2 = e;
    @(posedge clk); #1;
    ce2 = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel == 1) ? busy : busy2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_%0d", sel), (sel == 1) ? busy : busy2, 0);
  endtask

  initial begin
    int p0, i0, d0;
    reset_in_n = 1'b0; enable = 1'b1;
    ce = 1'b0; err = '0; ce2 = 1'b0; err2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_in_n = 1'b1;
    @(negedge clk);
    chk("rst_psen", psen, 0);
    chk("rst_psincdec", psincdec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pos", pos, 0);
    chk("rst_terr", terr, 0);

    // burst of 3 increments, psdone 3 cycles after each psen
    resp_on = 1'b1; resp_dly = 3;
    p0 = pulses; i0 = incs;
    send(32'sd7);
    chk("b3_psen_n1", psen, 1);
    chk("b3_busy_n1", busy, 1);
    tick(11);
    chk("b3_busy_m", busy, 1);
    tick(1);
    chk("b3_busy_m1", busy, 0);
    chk("b3_pulses", pulses - p0, 3);
    chk("b3_incs", incs - i0, 3);
    chk("b3_pos", pos, 3);

    // deadband: -4 does nothing
    p0 = pulses;
    send(-32'sd4);
    chk("db_busy", busy, 0);
    tick(3);
    chk("db_pulses", pulses - p0, 0);

    // clamp: -100 -> 8 decrements
    p0 = pulses; d0 = decs;
    send(-32'sd100);
    wait_idle(1, 200);
    chk("clamp_pulses", pulses - p0, 8);
    chk("clamp_decs", decs - d0, 8);
    chk("clamp_pos", pos, -5);

    // most-negative input saturates magnitude -> 8 decrements
    p0 = pulses; d0 = decs;
    send(32'sh80000000);
    wait_idle(1, 200);
    chk("minneg_decs", decs - d0, 8);
    chk("minneg_pos", pos, -13);

    // psdone exactly at the terminal count counts as done
    resp_dly = 63;
    send(32'sd5);
    wait_idle(1, 200);
    chk("tc_done_pos", pos, -12);
    chk("tc_done_terr", terr, 0);

    // timeout: psdone never returns
    resp_on = 1'b0; resp_dly = 3;
    p0 = pulses;
    send(32'sd10);
    chk("tmo_psen", psen, 1);
    tick(63);
    chk("tmo_terr_early", terr, 0);
    chk("tmo_busy_early", busy, 1);
    tick(1);
    chk("tmo_terr", terr, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_pos", pos, -12);
    chk("tmo_pulses", pulses - p0, 1);

    // operation continues after a timeout
    resp_on = 1'b1;
    p0 = pulses;
    send(32'sd5);
    wait_idle(1, 200);
    chk("post_tmo_pulses", pulses - p0, 1);
    chk("post_tmo_pos", pos, -11);
    chk("post_tmo_terr", terr, 1);

    // second sample while busy is dropped
    p0 = pulses;
    send(32'sd20);
    tick(2);
    send(32'sd20);
    wait_idle(1, 200);
    chk("drop_pulses", pulses - p0, 8);
    chk("drop_pos", pos, -3);

    // enable drops after the 2nd psen
    p0 = pulses;
    send(32'sd20);
    tick(4);
    chk("en_psen2", psen, 1);
    enable = 1'b0;
    wait_idle(1, 200);
    tick(4);
    chk("en_pulses", pulses - p0, 2);
    chk("en_pos", pos, -1);
    enable = 1'b1;

    // async reset in the middle of WAIT
    resp_on = 1'b0;
    send(32'sd10);
    tick(2);
    #3 reset_in_n = 1'b0;
    #1;
    chk("arst_psen", psen, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pos", pos, 0);
    chk("arst_terr", terr, 0);
    @(negedge clk) reset_in_n = 1'b1;
    @(negedge clk) stray_pd = 1'b1;
    @(negedge clk) stray_pd = 1'b0;
    chk("stray_pos", pos, 0);
    chk("stray_busy", busy, 0);

    // 8-bit saturation: 127 increments, then one more stays at +127
    send2(8'sd127);
    wait_idle(2, 1000);
    chk("sat_pos_127", pos2, 127);
    p0 = pulses2; i0 = incs2;
    send2(8'sd1);
    wait_idle(2, 50);
    chk("sat_pulses", pulses2 - p0, 1);
    chk("sat_incs", incs2 - i0, 1);
    chk("sat_pos_hold", pos2, 127);
    chk("sat_terr", terr2, 0);

    // -128 magnitude saturates to 127 decrements
    d0 = decs2;
    send2(-8'sd128);
    wait_idle(2, 1000);
    chk("sat_minneg_decs", decs2 - d0, 127);
    chk("sat_minneg_pos", pos2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmcm_ps_stepper.md
# mmcm_ps_stepper

Actuation end of the MMCM servo loop. It consumes the signed, filtered phase-error samples produced by the moving-average stage and turns each accepted sample into a bounded burst of MMCM dynamic phase-shift steps. It drives PSEN/PSINCDEC and paces on PSDONE. It sits between the loop filter output and the MMCM DPS port, and keeps a running signed count of net applied steps.

## Interface
- WIDTH, 32, width of error input and position counter (signed)
- DEADBAND, 4, errors with |err| <= DEADBAND cause no steps
- MAX_STEPS, 8, maximum steps issued per accepted sample (1..255)
- PSDONE_TIMEOUT, 63, cycles waited in WAIT for psdone before fault (>=2)
- clk  input  1  single clock; also the MMCM PSCLK domain
- reset_in_n  input  1  asynchronous, active-low reset
- CE  input  1  sample strobe; err_in valid when high
- enable  input  1  servo run enable
- err_in  input  WIDTH  signed filtered phase error
- psen  output  1  MMCM PSEN, one-cycle pulse per step
- psincdec  output  1  MMCM PSINCDEC; 1 = increment
- psdone  input  1  MMCM PSDONE
- busy  output  1  high whenever state != IDLE
- position  output  WIDTH  signed net completed steps
- timeout_err  output  1  sticky PSDONE-timeout flag

## Operation
- FSM states are IDLE, PULSE, WAIT.
- **IDLE**
  - On CE=1 with enable=1, compute mag = |err_in|.
  - For the most-negative err_in, mag saturates to 2^(WIDTH-1)-1.
  - If mag <= DEADBAND, stay in IDLE.
  - Otherwise:
    - remaining = min(mag - DEADBAND, MAX_STEPS)
    - dir = (err_in > 0)
    - go to PULSE.
- **PULSE**
  - psen=1 for exactly this cycle and psincdec=dir.
  - Decrement remaining, clear the timeout counter, go to WAIT.
- **WAIT**
  - psincdec is held at dir.
  - On psdone=1:
    - position += dir ? +1 : -1, saturating at signed WIDTH limits.
    - If remaining>0 and enable=1, go to PULSE; else go to IDLE and discard remaining.
  - If PSDONE_TIMEOUT cycles elapse without psdone:
    - Set timeout_err.
    - Discard remaining, position unchanged, go to IDLE.
- CE while busy is ignored (sample dropped, no queueing).
- psdone outside WAIT is ignored.
- enable falling during a burst:
  - The outstanding step still completes, or times out.
  - No further PSEN is issued.
- timeout_err clears only on reset. It does not block further operation.
- Reset values:
  - state=IDLE, psen=0, psincdec=0, busy=0, position=0, timeout_err=0, remaining=0.
  - Reset takes effect asynchronously. Assertion mid-burst drops psen immediately.

## Timing
- CE accepted in cycle N gives psen=1 in cycle N+1 (registered) and busy=1 from N+1.
- psdone in cycle M while in WAIT:
  - position updates visibly at M+1.
  - The next psen, if any, is at M+1.
  - Minimum step period is 2 cycles.
- If the burst ends at M, busy=0 at M+1, and CE at M+1 is accepted.
- The timeout counter starts at 0 in the first WAIT cycle.
  - Fault when the counter reaches PSDONE_TIMEOUT-1 with no psdone.
  - timeout_err=1 and busy=0 the following cycle.
- psdone in the same cycle as the timeout terminal count counts as done, not fault.
- Arithmetic:
  - mag - DEADBAND is computed in WIDTH bits unsigned.
  - The clamp compare uses a full-width value. It is truncated to ceil(log2(MAX_STEPS+1)) bits only after clamping.

## Structure
- Package mmcm_servo_pkg holds:
  - the state enum (IDLE/PULSE/WAIT)
  - the step-count width function
  - the PSINCDEC encoding constants (PS_INC=1, PS_DEC=0)
- One sub-module, ps_timeout_counter:
  - Loadable down-counter with clear and terminal-count output.
  - Parameterized by PSDONE_TIMEOUT.
- The remaining logic (magnitude/clamp, FSM, position saturation) stays in mmcm_ps_stepper.

## Test plan
- **Burst of 3 increments.** err_in=+7, DEADBAND=4, psdone returned 3 cycles after each psen.
  - Exactly 3 psen pulses with psincdec=1.
  - position=+3.
  - busy falls 1 cycle after the third psdone.
- **Deadband and clamp.**
  - err_in=-4 gives no psen and busy stays 0.
  - err_in=-100 gives 8 pulses with psincdec=0 and position=-8.
  - err_in=0x80000000 gives 8 decrement pulses with no overflow.
- **Timeout.** err_in=+10, psdone never asserted.
  - One psen pulse.
  - timeout_err=1 exactly PSDONE_TIMEOUT cycles after entering WAIT.
  - position=0, busy=0.
  - A subsequent CE with err_in=+5 still issues 1 step.
- **Dropped sample and late enable.**
  - CE with err_in=+20 pulsed again mid-burst: the second sample is ignored (8 steps total).
  - enable dropped after the 2nd psen: the 2nd step completes, position=+2, no third psen.
- **Async reset mid-WAIT.** reset_in_n driven low between clock edges.
  - psen=0, busy=0, position=0, timeout_err=0 immediately.
  - A stray psdone after release does not change position.
- **Position saturation.** Preload with WIDTH=8 and position=+127; one more increment step keeps position at +127.
